// File: rtl/clk_tick_bank.sv
// -----------------------------------------------------------------------------
// clk_tick_bank
//
// Bank of NUM_CH independent programmable clock dividers running off CLK_50.
// Each channel produces a 50%-duty square wave (clk_sq) with period
// 2*half cycles and a one-cycle tick on every rising edge of that square.
// Half-periods are loaded at reset from HALF_INIT and can be rewritten at
// runtime; a write or a global sync restarts the affected channel(s).
//
// Ports
//   CLK_50   in   system clock, everything on the rising edge
//   nRST     in   asynchronous active-low reset
//   ch_en    in   per-channel run enable (held count/output when low)
//   sync     in   synchronous restart of every channel
//   wr_en    in   half-period write strobe
//   wr_ch    in   channel index for the write
//   wr_half  in   new half-period in CLK_50 cycles (0 is rejected)
//   clk_sq   out  registered square outputs
//   tick     out  registered one-cycle pulse at each clk_sq rise
//   wr_ack   out  pulse: write in the previous cycle was accepted
//   wr_err   out  pulse: write in the previous cycle was rejected
// -----------------------------------------------------------------------------
module clk_tick_bank #(
    parameter int unsigned                 NUM_CH    = 5,
    parameter int unsigned                 CNT_W     = 26,
    parameter logic [NUM_CH*CNT_W-1:0]     HALF_INIT = {NUM_CH{26'd25000000}},
    parameter int unsigned                 CH_W      = 4
) (
    input  logic              CLK_50,
    input  logic              nRST,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] clk_sq,
    output logic [NUM_CH-1:0] tick,
    output logic              wr_ack,
    output logic              wr_err
);

    // Channel count widened by one bit so the range check works even when
    // NUM_CH == 2^CH_W.
    localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  half_q [NUM_CH];
    logic [CNT_W-1:0]  half_d [NUM_CH];
    logic [NUM_CH-1:0] sq_q,   sq_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              ack_q,  ack_d;
    logic              err_q,  err_d;

    logic              wr_acc;

    assign wr_acc = wr_en && ({1'b0, wr_ch} < NUM_CH_W) && (wr_half != '0);

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        sq_d   = sq_q;
        tick_d = '0;
        ack_d  = wr_acc;
        err_d  = wr_en && !wr_acc;

        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // The half-period store is independent of sync: a write that
            // coincides with sync still lands, only the restart is global.
            if (wr_acc && (wr_ch == CH_W'(i))) begin
                half_d[i] = wr_half;
            end

            if (sync || (wr_acc && (wr_ch == CH_W'(i)))) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (ch_en[i]) begin
                // >= rather than == so a count that somehow sits past the
                // terminal value still wraps instead of running to overflow.
                if (cnt_q[i] >= (half_q[i] - CNT_W'(1))) begin
                    cnt_d[i]  = '0;
                    sq_d[i]   = ~sq_q[i];
                    tick_d[i] = ~sq_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_50 or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                half_q[i] <= HALF_INIT[i*CNT_W +: CNT_W];
            end
            sq_q   <= '0;
            tick_q <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            sq_q   <= sq_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign clk_sq = sq_q;
    assign tick   = tick_q;
    assign wr_ack = ack_q;
    assign wr_err = err_q;

endmodule

// File: tb/tb_clk_tick_bank.sv
// -----------------------------------------------------------------------------
// tb_clk_tick_bank
//
// Directed plus random stimulus against a reference model that tracks, per
// channel, how many enabled edges have elapsed since the last restart; the
// square level and tick follow arithmetically from that count and the
// half-period.
// -----------------------------------------------------------------------------
module tb_clk_tick_bank;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 8;
    localparam int unsigned HW  = 2;
    localparam logic [NCH*CW-1:0] HINIT = {8'd5, 8'd2, 8'd1};

    logic            clk;
    logic            rst_n;
    logic [NCH-1:0]  ch_en;
    logic            sync;
    logic            wr_en;
    logic [HW-1:0]   wr_ch;
    logic [CW-1:0]   wr_half;
    logic [NCH-1:0]  clk_sq;
    logic [NCH-1:0]  tick;
    logic            wr_ack;
    logic            wr_err;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // reference model state
    int          m_n    [NCH];
    int          m_h    [NCH];
    logic [NCH-1:0] m_tick;
    logic        m_ack, m_err;

    clk_tick_bank #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .HALF_INIT (HINIT),
        .CH_W      (HW)
    ) dut (
        .CLK_50  (clk),
        .nRST    (rst_n),
        .ch_en   (ch_en),
        .sync    (sync),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_half (wr_half),
        .clk_sq  (clk_sq),
        .tick    (tick),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NCH-1:0] m_sq();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = ((m_n[i] / m_h[i]) % 2) == 1;
        return r;
    endfunction

    task automatic model_reset();
        m_h[0] = 1; m_h[1] = 2; m_h[2] = 5;
        for (int i = 0; i < NCH; i++) m_n[i] = 0;
        m_tick = '0; m_ack = 1'b0; m_err = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".clk_sq"}, 8'(clk_sq), 8'(m_sq()));
        chk({tag, ".tick"},   8'(tick),   8'(m_tick));
        chk({tag, ".wr_ack"}, 8'(wr_ack), 8'(m_ack));
        chk({tag, ".wr_err"}, 8'(wr_err), 8'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model over the edge, check.
    task automatic step(input logic [NCH-1:0] en, input logic s, input logic we,
                        input logic [HW-1:0] ch, input logic [CW-1:0] hv,
                        input string tag);
        logic acc;
        ch_en = en; sync = s; wr_en = we; wr_ch = ch; wr_half = hv;
        @(posedge clk);
        acc   = we && (int'(ch) < NCH) && (hv != 0);
        m_ack = acc;
        m_err = we && !acc;
        if (acc) m_h[ch] = int'(hv);
        for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 1'b0;
            if (s || (acc && int'(ch) == i)) begin
                m_n[i] = 0;
            end else if (en[i]) begin
                m_n[i] = m_n[i] + 1;
                m_tick[i] = (m_n[i] % (2 * m_h[i])) == m_h[i];
                m_n[i] = m_n[i] % (2 * m_h[i]);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step('1, 1'b0, 1'b0, '0, '0, tag);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; ch_en = '1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // free run from reset: ch0 half 1, ch1 half 2, ch2 half 5
        idle(22, "freerun");

        // write ch1 half=3 while ch1 is high
        guard = 0;
        while (!(m_sq() & 3'b010) && guard < 10) begin
            idle(1, "seek_ch1_high"); guard++;
        end
        chk("seek_ch1_high_bound", 8'(guard < 10), 8'd1);
        step('1, 1'b0, 1'b1, 2'd1, 8'd3, "wr_ch1_h3");
        idle(14, "ch1_period6");

        // rejected writes
        step('1, 1'b0, 1'b1, 2'd3, 8'd4, "wr_bad_ch");
        step('1, 1'b0, 1'b1, 2'd2, 8'd0, "wr_zero_half");
        idle(12, "after_rejects");

        // sync while ch2 sits at its terminal count (cnt=4, about to toggle)
        guard = 0;
        while ((m_n[2] % 5) != 4 && guard < 12) begin
            idle(1, "seek_ch2_term"); guard++;
        end
        chk("seek_ch2_term_bound", 8'(guard < 12), 8'd1);
        step('1, 1'b1, 1'b0, '0, '0, "sync");
        idle(12, "after_sync");

        // sync coinciding with an accepted write
        step('1, 1'b1, 1'b1, 2'd0, 8'd2, "sync_and_write");
        idle(10, "after_sync_wr");

        // freeze ch2 at cnt=2 with clk_sq[2]=1 for 7 cycles
        guard = 0;
        while (m_n[2] != 7 && guard < 12) begin
            idle(1, "seek_ch2_hold"); guard++;
        end
        chk("seek_ch2_hold_bound", 8'(guard < 12), 8'd1);
        for (int k = 0; k < 7; k++) step(3'b011, 1'b0, 1'b0, '0, '0, "ch2_hold");
        idle(8, "ch2_resume");

        // back-to-back writes, same channel then different
        step('1, 1'b0, 1'b1, 2'd2, 8'd4, "b2b_0");
        step('1, 1'b0, 1'b1, 2'd2, 8'd3, "b2b_1");
        step('1, 1'b0, 1'b1, 2'd1, 8'd1, "b2b_2");
        idle(10, "after_b2b");

        // random phase
        for (int k = 0; k < 400; k++) begin
            logic [NCH-1:0] en;
            logic s, we;
            en = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            s  = ($urandom_range(0, 40) == 0);
            we = ($urandom_range(0, 7) == 0);
            step(en, s, we, HW'($urandom_range(0, 3)), CW'($urandom_range(0, 6)), "random");
        end

        // write ch1 half=3, then asynchronous reset mid-cycle
        step('1, 1'b0, 1'b1, 2'd1, 8'd3, "pre_rst_wr");
        idle(3, "pre_rst_run");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(16, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
